// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, arbiter FSM states
// and the default value returned on an errored load.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC,
    SCFAIL
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_link_reg.sv
// LL/SC link register: remembers the word address of the last load-linked and
// drops the link when a conflicting write or clear event is seen.
module mem_link_reg
  import cpu_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [29:0] set_addr,
  input  logic        clear,
  input  logic        snoop_valid,
  input  logic [29:0] snoop_addr,
  input  logic [29:0] cmp_addr,
  output logic        hit
);

  logic [29:0] linkaddr;
  logic        linkvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      linkaddr  <= '0;
      linkvalid <= 1'b0;
    end else if (set) begin
      linkaddr  <= set_addr;
      linkvalid <= 1'b1;
    end else if (clear || (snoop_valid && snoop_addr == linkaddr)) begin
      linkvalid <= 1'b0;
    end
  end

  assign hit = linkvalid && (linkaddr == cmp_addr);

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter: data-over-instruction priority, latched RAM
// requests, LL/SC link tracking, access timeout and sticky error flag.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        datomic,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_t    state, next;
  ramstate_t     rs;
  logic [CW-1:0] cnt;
  logic          ren_q, wen_q, atomic_q;
  logic [31:0]   addr_q, store_q;
  logic          link_hit, acc, fail, done, grant_d, grant_i;
  logic          in_dacc;

  assign rs      = ramstate_t'(ramstate);
  assign acc     = (rs == ACCESS);
  // ACCESS takes precedence over a timeout expiring in the same cycle
  assign fail    = !acc && ((rs == ERROR) || (cnt == CW'(TIMEOUT)));
  assign in_dacc = (state == DACC);

  always_comb begin
    next    = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    done    = 1'b0;
    iwait   = iREN;
    dwait   = dREN | dWEN;
    iload   = '0;
    dload   = '0;
    unique case (state)
      IDLE: begin
        if (dREN | dWEN) begin
          if (dWEN && datomic && !link_hit) begin
            next = SCFAIL;
          end else begin
            next    = DACC;
            grant_d = 1'b1;
          end
        end else if (iREN) begin
          next    = IACC;
          grant_i = 1'b1;
        end
      end
      DACC: begin
        if (acc || fail) begin
          done  = 1'b1;
          next  = IDLE;
          dwait = 1'b0;
          if (fail)                  dload = ERR_DATA;
          else if (wen_q && atomic_q) dload = 32'd1;
          else                        dload = ramload;
        end
      end
      IACC: begin
        if (acc || fail) begin
          done  = 1'b1;
          next  = IDLE;
          iwait = 1'b0;
          iload = fail ? ERR_DATA : ramload;
        end
      end
      SCFAIL: begin
        next  = IDLE;
        dwait = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      atomic_q <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      cnt      <= '0;
      merr     <= 1'b0;
    end else begin
      state <= next;
      if (grant_d) begin
        ren_q    <= !dWEN;
        wen_q    <= dWEN;
        atomic_q <= datomic;
        addr_q   <= daddr;
        store_q  <= dstore;
        cnt      <= '0;
      end else if (grant_i) begin
        ren_q    <= 1'b1;
        wen_q    <= 1'b0;
        atomic_q <= 1'b0;
        addr_q   <= iaddr;
        cnt      <= '0;
      end else if (done) begin
        ren_q <= 1'b0;
        wen_q <= 1'b0;
      end else if (state == DACC || state == IACC) begin
        cnt <= cnt + 1'b1;
      end
      if (done && fail) merr <= 1'b1;
    end
  end

  mem_link_reg u_link (
    .clk         (CLK),
    .rst         (RST),
    .set         (done && acc && in_dacc && ren_q && atomic_q),
    .set_addr    (addr_q[31:2]),
    .clear       ((done && acc && in_dacc && wen_q && atomic_q) ||
                  (state == SCFAIL) || (done && fail)),
    .snoop_valid (done && acc && in_dacc && wen_q && !atomic_q),
    .snoop_addr  (addr_q[31:2]),
    .cmp_addr    (daddr[31:2]),
    .hit         (link_hit)
  );

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-core memory arbiter sitting between the datapath's instruction-fetch port, its data port (driven by the control unit's dREN/dWEN/atomic decode), and one single-ported RAM. It serialises requests with data-over-instruction priority, holds the RAM request stable until the RAM reports ACCESS, and implements the LL/SC link register that gives `atomic` its meaning. It also bounds RAM latency with a timeout and reports RAM errors.

## Interface
- TIMEOUT, 255: maximum cycles a granted access may wait for ACCESS before forced error completion (1..1023).
- ERR_DATA, 32'hBAD1BAD1: load value returned on error completion.

- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction read data, valid when iREN && !iwait
- iwait  out  1  instruction port stall
- dREN  in  1  data read request
- dWEN  in  1  data write request; wins if asserted together with dREN
- datomic  in  1  qualifies dREN as LL, dWEN as SC
- daddr  in  32  data address
- dstore  in  32  data write value
- dload  out  32  read data; for SC, 1 = success, 0 = fail
- dwait  out  1  data port stall
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- merr  out  1  sticky error flag, cleared only by RST

## Operation
- FSM states: IDLE, DACC, IACC, SCFAIL.
- IDLE: if dREN|dWEN: if SC and link miss -> SCFAIL, else -> DACC; else if iREN -> IACC; else stay. Data always wins a same-cycle tie.
- DACC/IACC: the address, store data and strobe are latched at grant; RAM outputs are driven from the latches and held constant until completion, even if the requester drops its request. Completion occurs when ramstate==ACCESS, ramstate==ERROR, or the timeout counter reaches TIMEOUT. On completion -> IDLE.
- SCFAIL: the RAM is not touched; the data port completes with dload=0; -> IDLE.
- Completion cycle: the matching wait output is low for exactly that cycle.
  - Load data: ramload on ACCESS, ERR_DATA on error/timeout. iload and dload are combinational from ramload in that cycle.
  - A successful SC returns dload=1 instead of the RAM value.
- Outside completion: iwait = iREN and dwait = dREN|dWEN.
- Link register: linkaddr[31:2] and linkvalid.
  - LL completing via ACCESS sets linkaddr = daddr[31:2] and linkvalid = 1.
  - SC hit requires linkvalid && linkaddr==daddr[31:2].
  - linkvalid clears on any ACCESS-completed SC (regardless of outcome), on SCFAIL, and on a plain write whose word address matches linkaddr.
  - Error/timeout completion clears linkvalid.
- Timeout counter: width clog2(TIMEOUT+1). Cleared at grant, increments each non-completing cycle of DACC/IACC.
- merr is set on any error or timeout completion.

## Timing
- Reset values: state IDLE, ramREN=ramWEN=0, ramaddr=ramstore=0, linkvalid=0, linkaddr=0, counter 0, merr=0; iwait/dwait follow their requests, loads 0.
- RST mid-access: the strobes drop at the next edge; the in-flight access is abandoned with no completion pulse.
- Grant is registered: a request sampled in IDLE at edge N has its RAM strobe from cycle N+1.
- Latency:
  - Minimum 2 cycles from request to wait low (RAM returns ACCESS in its first strobed cycle).
  - There is always one IDLE bubble after completion.
  - An SC failure takes 2 cycles.
- Requests are level-sensitive. The requester holds address/data until its wait output falls; the arbiter re-arbitrates only in IDLE.

## Structure
- cpu_types_pkg gains:
  - ramstate_t enum.
  - arb_state_t enum (IDLE, DACC, IACC, SCFAIL).
  - ERR_DATA default constant.
- One sub-module is natural: mem_link_reg holds linkaddr/linkvalid. Its interface:
  - inputs: set, clear, snoop write address/valid, compare address.
  - output: hit.
- The FSM, counter and muxing stay in mem_arbiter.

## Test plan
- Simultaneous iREN (iaddr=0x100) and dREN (daddr=0x200), RAM ACCESS after 2 BUSY cycles -> data served first (dwait low at cycle 4), then a bubble, then the instruction fetch; ramaddr sequence 0x200 then 0x100.
- LL 0x40, then SC 0x40 dstore=0x55 -> SC writes RAM, dload=1, linkvalid=0; a second SC 0x40 -> SCFAIL, no ramWEN, dload=0.
- LL 0x40, plain write to 0x42 (same word), SC 0x40 -> SC fails; LL 0x40, plain write to 0x44, SC 0x40 -> succeeds.
- ramstate held BUSY with TIMEOUT=4 -> completion after 4 stalled cycles, dload=0xBAD1BAD1, merr=1 sticky until RST.
- ramstate=ERROR on an instruction fetch -> iwait low that cycle, iload=ERR_DATA, merr=1.
- RST asserted during DACC with ramWEN high -> ramWEN=0 and state IDLE after the next edge, no dwait low pulse, linkvalid=0.
